// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB/APB encodings and bridge control states
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ENABLE,
    ST_ERR1,
    ST_ERR2
  } ctrl_state_e;

endpackage

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - maps the top address byte and size to an APB one-hot select
module apb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter int         NSLV     = 4,
  parameter logic [7:0] SLV_BASE = 8'h80
) (
  input  logic [7:0]      i_haddr_msb,
  input  logic [2:0]      i_hsize,
  output logic            o_hit,
  output logic [NSLV-1:0] o_sel
);

  logic [7:0] w_offset;
  logic       w_in_range;

  assign w_offset   = i_haddr_msb - SLV_BASE;
  assign w_in_range = (i_haddr_msb >= SLV_BASE) && (w_offset < 8'(NSLV));
  assign o_hit      = w_in_range && (i_hsize == HSIZE_WORD);

  always_comb begin
    o_sel = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (o_hit && (w_offset == 8'(k))) o_sel[k] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb2apb_ctrl.sv
// rtl/ahb2apb_ctrl.sv - AHB-Lite single-beat to APB SETUP/ENABLE sequencing core
module ahb2apb_ctrl
  import ahb_apb_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter int         NSLV     = 4,
  parameter logic [7:0] SLV_BASE = 8'h80
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Hwrite,
  input  logic [2:0]        Hsize,
  input  logic [1:0]        Htrans,
  input  logic              Hreadyin,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  output logic [DATA_W-1:0] Hrdata,
  input  logic [DATA_W-1:0] Prdata,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable
);

  ctrl_state_e       r_state;
  ctrl_state_e       w_next;
  logic              w_active;
  logic              w_valid;
  logic              w_hit;
  logic [NSLV-1:0]   w_sel;
  logic [NSLV-1:0]   w_sel_cap;
  logic [NSLV-1:0]   r_sel;
  logic              r_hreadyout;
  logic [1:0]        r_hresp;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_pwrite;
  logic [NSLV-1:0]   r_pselx;
  logic              r_penable;

  apb_addr_decode #(
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE)
  ) u_decode (
    .i_haddr_msb (Haddr[ADDR_W-1:ADDR_W-8]),
    .i_hsize     (Hsize),
    .o_hit       (w_hit),
    .o_sel       (w_sel)
  );

  assign w_active  = (Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ);
  assign w_valid   = Hreadyin && w_active && r_hreadyout;
  // A read goes straight to SETUP, so its select must come from the live decode
  assign w_sel_cap = w_valid ? w_sel : r_sel;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_ENABLE, ST_ERR2: begin
        if (!w_valid)    w_next = ST_IDLE;
        else if (!w_hit) w_next = ST_ERR1;
        else if (Hwrite) w_next = ST_WDATA;
        else             w_next = ST_SETUP;
      end
      ST_WDATA: w_next = ST_SETUP;
      ST_SETUP: w_next = ST_ENABLE;
      ST_ERR1:  w_next = ST_ERR2;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_sel       <= '0;
      r_pselx     <= '0;
      r_penable   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_hreadyout <= (w_next == ST_IDLE) || (w_next == ST_ENABLE) || (w_next == ST_ERR2);
      r_hresp     <= ((w_next == ST_ERR1) || (w_next == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      r_pselx     <= ((w_next == ST_SETUP) || (w_next == ST_ENABLE)) ? w_sel_cap : '0;
      r_penable   <= (w_next == ST_ENABLE);
      if (w_valid) begin
        r_paddr  <= Haddr;
        r_pwrite <= Hwrite;
        r_sel    <= w_sel;
      end
      if (r_state == ST_WDATA) r_pwdata <= Hwdata;
    end
  end

  assign Hreadyout = r_hreadyout;
  assign Hresp     = r_hresp;
  assign Hrdata    = ((r_state == ST_ENABLE) && !r_pwrite) ? Prdata : '0;
  assign Paddr     = r_paddr;
  assign Pwdata    = r_pwdata;
  assign Pwrite    = r_pwrite;
  assign Pselx     = r_pselx;
  assign Penable   = r_penable;

endmodule

// File: tb/tb_ahb2apb_ctrl.sv
// tb/tb_ahb2apb_ctrl.sv - scoreboard bench for the AHB-to-APB control core
module tb_ahb2apb_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [1:0]  Htrans;
  logic        Hreadyin;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Prdata;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pwrite;
  logic [3:0]  Pselx;
  logic        Penable;

  typedef struct {
    bit          err;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  sel;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   wait_left = 0;
  bit   exp_ready = 1'b1;
  bit   mon_en = 1'b0;

  ahb2apb_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .Hwrite    (Hwrite),
    .Hsize     (Hsize),
    .Htrans    (Htrans),
    .Hreadyin  (Hreadyin),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .Prdata    (Prdata),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Pwrite    (Pwrite),
    .Pselx     (Pselx),
    .Penable   (Penable)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got unexpected bus activity, required none (cycle %0d)", nm, cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, 32'(Hreadyout), 32'd1);
    chk({tag, "_hresp"},     32'(Hresp),     32'd0);
    chk({tag, "_hrdata"},    Hrdata,         32'd0);
    chk({tag, "_paddr"},     Paddr,          32'd0);
    chk({tag, "_pwdata"},    Pwdata,         32'd0);
    chk({tag, "_pwrite"},    32'(Pwrite),    32'd0);
    chk({tag, "_pselx"},     32'(Pselx),     32'd0);
    chk({tag, "_penable"},   32'(Penable),   32'd0);
  endtask

  // Expected-ready model: a data phase lasts lat cycles, ready only on the last one
  task automatic step(input bit acc_now, input int lat, input logic [31:0] wd_next);
    @(posedge clock);
    if (acc_now) wait_left = lat - 1;
    else if (wait_left > 0) wait_left--;
    exp_ready = (wait_left == 0);
    @(negedge clock);
    Hwdata = wd_next;
    Prdata = $urandom;
  endtask

  task automatic present(input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                         input logic [2:0] sz, input logic rdyin, input logic [31:0] wd);
    exp_t       e;
    bit         acc;
    bit         hit;
    logic [7:0] pg;
    while (!exp_ready) begin
      Htrans   = 2'($urandom_range(0, 3));
      Haddr    = $urandom;
      Hwrite   = 1'($urandom_range(0, 1));
      Hsize    = 3'($urandom_range(0, 7));
      Hreadyin = 1'($urandom_range(0, 1));
      step(1'b0, 0, $urandom);
    end
    Htrans   = tr;
    Hwrite   = wr;
    Haddr    = addr;
    Hsize    = sz;
    Hreadyin = rdyin;
    acc = rdyin && (tr == 2'b10 || tr == 2'b11);
    pg  = addr[31:24];
    hit = (pg >= 8'h80) && (pg <= 8'h83) && (sz == 3'b010);
    e = '{err: 1'b0, wr: 1'b0, addr: 32'd0, wd: 32'd0, sel: 4'd0, acc: 0, lat: 0};
    if (acc) begin
      e.err  = !hit;
      e.wr   = wr;
      e.addr = addr;
      e.wd   = wd;
      e.sel  = hit ? 4'(1 << (pg - 8'h80)) : 4'b0000;
      e.acc  = cyc + 1;
      e.lat  = (hit && wr) ? 3 : 2;
      q.push_back(e);
    end
    step(acc, e.lat, (acc && hit && wr) ? wd : $urandom);
  endtask

  task automatic monitor_cycle();
    exp_t e;
    chk("hreadyout", 32'(Hreadyout), 32'(exp_ready));
    if (!Penable) chk("hrdata_zero", Hrdata, 32'd0);
    if (Penable) begin
      if (q.size() == 0) fail("enable_unexpected");
      else begin
        e = q.pop_front();
        if (e.err) fail("enable_on_error_xfer");
        chk("en_pselx",   32'(Pselx),  32'(e.sel));
        chk("en_paddr",   Paddr,       e.addr);
        chk("en_pwrite",  32'(Pwrite), 32'(e.wr));
        chk("en_hresp",   32'(Hresp),  32'd0);
        chk("en_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        if (e.wr) begin
          chk("en_pwdata", Pwdata, e.wd);
          chk("en_hrdata_wr", Hrdata, 32'd0);
        end else begin
          chk("en_hrdata", Hrdata, Prdata);
        end
      end
    end else if (Pselx != 4'd0) begin
      if (q.size() == 0) fail("setup_unexpected");
      else begin
        chk("su_pselx",  32'(Pselx),  32'(q[0].sel));
        chk("su_paddr",  Paddr,       q[0].addr);
        chk("su_pwrite", 32'(Pwrite), 32'(q[0].wr));
        chk("su_hresp",  32'(Hresp),  32'd0);
        if (q[0].wr) chk("su_pwdata", Pwdata, q[0].wd);
      end
    end else if (Hresp != 2'b00) begin
      if (q.size() == 0) fail("error_unexpected");
      else if (!q[0].err) fail("error_on_good_xfer");
      else begin
        chk("err_hresp", 32'(Hresp), 32'd1);
        if (Hreadyout) begin
          e = q.pop_front();
          chk("err_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (mon_en && !reset) monitor_cycle();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  pg;
    logic [2:0]  sz;
    logic [1:0]  tr;
    int          r;
    reset = 1'b1; Hwrite = 1'b0; Hsize = 3'b010; Htrans = 2'b00; Hreadyin = 1'b1;
    Haddr = '0; Hwdata = '0; Prdata = '0;
    #3;
    check_reset_outputs("rst0");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;

    present(2'b10, 1'b0, 32'h8000_0010, 3'b010, 1'b1, 32'h0);
    present(2'b10, 1'b1, 32'h8200_0004, 3'b010, 1'b1, 32'h1234_5678);
    present(2'b10, 1'b1, 32'h8100_0000, 3'b010, 1'b1, 32'hCAFE_0001);
    present(2'b10, 1'b0, 32'h8300_0000, 3'b010, 1'b1, 32'h0);
    present(2'b10, 1'b0, 32'h9000_0000, 3'b010, 1'b1, 32'h0);
    present(2'b10, 1'b0, 32'h8000_0000, 3'b000, 1'b1, 32'h0);
    present(2'b01, 1'b0, 32'h8000_0000, 3'b010, 1'b1, 32'h0);
    present(2'b10, 1'b0, 32'h8000_0000, 3'b010, 1'b0, 32'h0);
    present(2'b11, 1'b1, 32'h83FF_FFFC, 3'b010, 1'b1, 32'hA5A5_5A5A);
    present(2'b10, 1'b1, 32'h8400_0000, 3'b010, 1'b1, 32'h0);
    present(2'b10, 1'b0, 32'h7F00_0000, 3'b010, 1'b1, 32'h0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) pg = 8'h80 + 8'(r % 4);
      else if (r == 6) pg = 8'h84;
      else if (r == 7) pg = 8'h7F;
      else begin
        a  = $urandom;
        pg = a[7:0];
      end
      a = $urandom;
      a[31:24] = pg;
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      r  = $urandom_range(0, 9);
      tr = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
      present(tr, 1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 7) != 0), $urandom);
    end
    repeat (6) present(2'b00, 1'b0, 32'h0, 3'b010, 1'b1, 32'h0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    present(2'b10, 1'b0, 32'h8100_0020, 3'b010, 1'b1, 32'h0);
    @(posedge clock);
    #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    q.delete();
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clock);
    reset = 1'b0;
    Htrans = 2'b00;
    wait_left = 0;
    exp_ready = 1'b1;
    mon_en = 1'b1;
    present(2'b10, 1'b0, 32'h8300_0040, 3'b010, 1'b1, 32'h0);
    present(2'b10, 1'b1, 32'h8000_0008, 3'b010, 1'b1, 32'h0BAD_BEEF);
    repeat (4) present(2'b00, 1'b0, 32'h0, 3'b010, 1'b1, 32'h0);
    chk("queue_drained_end", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb2apb_ctrl.md
Name: ahb2apb_ctrl

Overview:
- Control and sequencing core of the AHB-to-APB bridge.
- Accepts single AHB-Lite slave transfers and converts each into one APB SETUP/ENABLE transfer.
- Decodes the address into one of four APB peripheral selects and issues an AHB ERROR response for unsupported accesses.
- Sits between the AHB master-side signals (H*) and the APB peripheral bus (P*) that the bridge testbench drives and monitors.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- NSLV, 4: number of APB selects; width of Pselx.
- SLV_BASE, 8'h80: Haddr[31:24] value of slave 0. Slave k occupies SLV_BASE+k.

Ports:
- clock  in  1  bridge clock; all state changes on rising edge
- reset  in  1  asynchronous reset, active-high
- Hwrite  in  1  1=write, 0=read
- Hsize  in  3  transfer size; only 3'b010 (word) is legal
- Htrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
- Hreadyin  in  1  bus-level ready; address phase is sampled only when 1
- Haddr  in  ADDR_W  transfer address
- Hwdata  in  DATA_W  write data, valid in the data phase
- Hreadyout  out  1  0 extends the current data phase
- Hresp  out  2  00=OKAY, 01=ERROR
- Hrdata  out  DATA_W  read data
- Prdata  in  DATA_W  APB read data
- Paddr  out  ADDR_W  registered APB address
- Pwdata  out  DATA_W  registered APB write data
- Pwrite  out  1  registered APB direction
- Pselx  out  NSLV  one-hot APB select
- Penable  out  1  APB enable strobe

Behaviour:
- Reset: async assert forces state IDLE, Hreadyout=1, Hresp=00, Hrdata=0, Paddr=0, Pwdata=0, Pwrite=0, Pselx=0, Penable=0. This also applies mid-transfer; an in-flight APB cycle is abandoned.
- Valid request: Hreadyin && Htrans[1] && Hreadyout, sampled at the rising edge.
  - Htrans IDLE or BUSY is ignored with zero-wait OKAY.
- Hit: Haddr[31:24] in SLV_BASE..SLV_BASE+NSLV-1 and Hsize==3'b010.
  - Pselx bit = Haddr[31:24]-SLV_BASE.
  - Any other valid request is a miss.
- On a valid request, Paddr, Pwrite and the decoded select index are captured into registers.
- States (Moore outputs; Hreadyout/Hresp are decoded from state only):
  - IDLE: Hreadyout=1, Hresp=00, Pselx=0, Penable=0.
    - Valid hit read -> SETUP.
    - Valid hit write -> WDATA.
    - Valid miss -> ERR1.
  - WDATA: Hreadyout=0. Pwdata<=Hwdata at exit edge. -> SETUP.
  - SETUP: Hreadyout=0, Pselx=captured one-hot, Penable=0. -> ENABLE.
  - ENABLE: Pselx held, Penable=1, Hreadyout=1, Hresp=00. If read, Hrdata=Prdata (combinational pass-through), else Hrdata=0.
    - Exit same as IDLE, using the request pipelined on this edge (back-to-back transfers, no idle bubble).
  - ERR1: Hreadyout=0, Hresp=01, Pselx=0. -> ERR2.
  - ERR2: Hreadyout=1, Hresp=01. Exit same as IDLE.
- Latency after the address-phase edge:
  - Read: data phase 2 cycles (SETUP, ENABLE).
  - Write: data phase 3 cycles (WDATA, SETUP, ENABLE).
  - Error: 2 cycles.
- Paddr/Pwrite/Pwdata remain stable from SETUP through ENABLE and hold their last value otherwise.
- Hrdata=0 in every state except read-ENABLE.
- Bursts (SEQ) are handled as independent single beats; Hburst is not used.

Decomposition:
- Package ahb_apb_pkg:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ)
  - HRESP_OKAY/HRESP_ERROR
  - HSIZE_WORD
  - ctrl_state_e (IDLE, WDATA, SETUP, ENABLE, ERR1, ERR2)
- Sub-module apb_addr_decode (combinational):
  - In: Haddr, Hsize.
  - Out: hit, one-hot select (NSLV bits).

Test Plan:
- Reset asserted for 3 cycles mid-ENABLE -> all outputs at reset values immediately, Hreadyout=1; after release, IDLE.
- Read NONSEQ Haddr=32'h8000_0010, Prdata=32'hCAFE_F00D -> SETUP: Pselx=0001, Penable=0; ENABLE: Penable=1, Hreadyout=1, Hrdata=32'hCAFE_F00D, Hresp=00.
- Write Haddr=32'h8200_0004, Hwdata=32'h1234_5678 -> WDATA (Hreadyout=0), SETUP with Pselx=0100, Pwrite=1, Paddr=32'h8200_0004, Pwdata=32'h1234_5678, then ENABLE.
- Back-to-back: write to 0x8100_0000 then read from 0x8300_0000 presented during write-ENABLE -> read SETUP on the next cycle with Pselx=1000, no idle cycle.
- Haddr=32'h9000_0000, and separately Hsize=3'b000 to 0x8000_0000 -> Hresp=01 for 2 cycles (Hreadyout 0 then 1), Pselx stays 0.
- Htrans=BUSY, and separately Hreadyin=0 with NONSEQ -> no APB activity, Hreadyout=1, Hresp=00.
